ws2812_rx: RTL and testbench

- Serial WS2812 receiver; the inverse of the neopixel transmit path.
- Samples a single-wire WS2812 data stream (loopback of ws2812_dout, or the DOUT of the last LED on the strip).
- Classifies pulse widths into bits, assembles 24-bit GRB pixels and reports pixel index plus frame boundaries.
- Used for on-board loopback checking of the hologram renderer and as a capture front end for processor MMIO.

---
 rtl/ws2812_pkg.sv | 29 ++
 rtl/ws2812_pulse_meter.sv | 62 ++++++
 rtl/ws2812_rx.sv | 168 ++++++++++++++++
 tb/tb_ws2812_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: constants and types shared by the WS2812 transmit and receive
// paths, so both ends agree on bit timing (100 MHz clock) and frame layout.
//   T0H / T1H      nominal high time of a 0 / 1 bit, in clock cycles
//   T_MIN_HIGH     shortest high pulse treated as a bit; shorter is a glitch
//   T_THRESH       high-time threshold: below = 0, at or above = 1
//   T_MAX_HIGH     high time above this is a protocol error
//   T_LATCH        low cycles that close a frame (50 us)
//   CNT_WIDTH      pulse counter width; must hold T_LATCH
//   BITS_PER_PIXEL GRB pixel size, MSB first
package ws2812_pkg;

  localparam int BITS_PER_PIXEL = 24;
  localparam int PX_COUNT_WIDTH = 6;
  localparam int T0H            = 40;
  localparam int T1H            = 80;
  localparam int T_MIN_HIGH     = 10;
  localparam int T_THRESH       = 60;
  localparam int T_MAX_HIGH     = 120;
  localparam int T_LATCH        = 5000;
  localparam int CNT_WIDTH      = 13;

  typedef enum logic [1:0] {
    ST_SYNC,  // waiting for the first latch gap; no bits accepted
    ST_IDLE,  // frame closed, line low
    ST_HIGH,  // measuring a high pulse
    ST_LOW    // inside a frame, measuring the low gap
  } rx_state_t;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// ws2812_pulse_meter: synchronises the raw WS2812 line and measures run
// lengths of the synchronised level.
//   clk, reset_n   system clock, asynchronous active-low reset
//   din            raw line, asynchronous to clk
//   rise / fall    one-cycle edge events on the synchronised line
//   width          on fall: number of cycles the line was high
//   long_high      one-cycle event when the high time exceeds T_MAX_HIGH
//   latch          one-cycle event when the line has been low T_LATCH cycles
// The counter restarts at 1 on every edge and saturates at all-ones, so each
// threshold event fires at most once per run.
module ws2812_pulse_meter #(
  parameter int CNT_WIDTH  = ws2812_pkg::CNT_WIDTH,
  parameter int T_MAX_HIGH = ws2812_pkg::T_MAX_HIGH,
  parameter int T_LATCH    = ws2812_pkg::T_LATCH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 din,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] width,
  output logic                 long_high,
  output logic                 latch
);

  localparam logic [CNT_WIDTH-1:0] MAX_HIGH_C = CNT_WIDTH'(T_MAX_HIGH);
  localparam logic [CNT_WIDTH-1:0] LATCH_C    = CNT_WIDTH'(T_LATCH - 1);

  logic                 sync_q1;
  logic                 sync_q2;
  logic                 level_q;
  logic [CNT_WIDTH-1:0] cnt;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      level_q <= sync_q2;
      if (sync_q2 != level_q)
        cnt <= CNT_WIDTH'(1);
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  // cnt equals the number of cycles the previous level lasted when an edge
  // is seen, and the completed run length minus one while the level holds.
  assign rise      = sync_q2 & ~level_q;
  assign fall      = ~sync_q2 & level_q;
  assign width     = cnt;
  assign long_high = sync_q2 & level_q & (cnt == MAX_HIGH_C);
  assign latch     = ~sync_q2 & ~level_q & (cnt == LATCH_C);

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Classifies pulse widths into bits,
// assembles GRB pixels MSB first and reports pixel index and frame ends.
//   clk, reset_n  system clock, asynchronous active-low reset
//   din           raw WS2812 line (asynchronous)
//   pixel         last assembled pixel, pixel_valid strobes when loaded
//   px_num        0-based index of the strobed pixel within the frame
//   frame_done    strobe on latch gap after at least one bit
//   frame_px      pixels in the completed frame (mod 2^PX_COUNT_WIDTH)
//   overflow      index wrapped this frame; cleared when the next frame starts
//   bit_err       strobe on over-long high pulse or partial pixel at latch
//   err_count     saturating bit_err count, only with WS2812_RX_ERRCNT_EN
module ws2812_rx #(
  parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL,
  parameter int PX_COUNT_WIDTH = ws2812_pkg::PX_COUNT_WIDTH,
  parameter int T_MIN_HIGH     = ws2812_pkg::T_MIN_HIGH,
  parameter int T_THRESH       = ws2812_pkg::T_THRESH,
  parameter int T_MAX_HIGH     = ws2812_pkg::T_MAX_HIGH,
  parameter int T_LATCH        = ws2812_pkg::T_LATCH,
  parameter int CNT_WIDTH      = ws2812_pkg::CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] px_num,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH-1:0] frame_px,
  output logic                      overflow,
  output logic                      bit_err
`ifdef WS2812_RX_ERRCNT_EN
  ,
  output logic [7:0]                err_count
`endif
);

  import ws2812_pkg::*;

  localparam int                   BC_W       = $clog2(BITS_PER_PIXEL);
  localparam logic [BC_W-1:0]      LAST_BIT   = BC_W'(BITS_PER_PIXEL - 1);
  localparam logic [CNT_WIDTH-1:0] MIN_HIGH_C = CNT_WIDTH'(T_MIN_HIGH);
  localparam logic [CNT_WIDTH-1:0] THRESH_C   = CNT_WIDTH'(T_THRESH);

  logic                      rise;
  logic                      fall;
  logic                      long_high;
  logic                      latch;
  logic [CNT_WIDTH-1:0]      width;

  rx_state_t                 state;
  logic                      from_low;   // context to return to after a glitch
  logic [BITS_PER_PIXEL-2:0] shreg;      // the newest bit completes the pixel
  logic [BC_W-1:0]           bit_cnt;
  logic [PX_COUNT_WIDTH-1:0] px_idx;
  logic                      bit_val;
  logic [BITS_PER_PIXEL-1:0] shreg_next;

  ws2812_pulse_meter #(
    .CNT_WIDTH  (CNT_WIDTH),
    .T_MAX_HIGH (T_MAX_HIGH),
    .T_LATCH    (T_LATCH)
  ) u_meter (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .rise      (rise),
    .fall      (fall),
    .width     (width),
    .long_high (long_high),
    .latch     (latch)
  );

  assign bit_val    = (width >= THRESH_C);
  assign shreg_next = {shreg, bit_val};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SYNC;
      from_low    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      px_idx      <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      px_num      <= '0;
      frame_done  <= 1'b0;
      frame_px    <= '0;
      overflow    <= 1'b0;
      bit_err     <= 1'b0;
    end else begin
      // NOTE: strobes default low here so any branch that raises one yields
      // exactly a one-cycle pulse without per-branch clearing.
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_err     <= 1'b0;

      case (state)
        ST_SYNC: begin
          if (latch)
            state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (rise) begin
            state    <= ST_HIGH;
            from_low <= 1'b0;
            overflow <= 1'b0;   // a new frame starts
          end
        end

        ST_HIGH: begin
          if (long_high) begin
            bit_err <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            px_idx  <= '0;
            state   <= ST_SYNC;
          end else if (fall) begin
            if (width < MIN_HIGH_C) begin
              state <= from_low ? ST_LOW : ST_IDLE;
            end else begin
              shreg <= shreg_next[BITS_PER_PIXEL-2:0];
              state <= ST_LOW;
              if (bit_cnt == LAST_BIT) begin
                pixel       <= shreg_next;
                pixel_valid <= 1'b1;
                px_num      <= px_idx;
                px_idx      <= px_idx + 1'b1;
                bit_cnt     <= '0;
                if (px_idx == '1)
                  overflow <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        ST_LOW: begin
          if (rise) begin
            state    <= ST_HIGH;
            from_low <= 1'b1;
          end else if (latch) begin
            frame_done <= 1'b1;
            frame_px   <= px_idx;
            bit_err    <= (bit_cnt != '0);
            shreg      <= '0;
            bit_cnt    <= '0;
            px_idx     <= '0;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

`ifdef WS2812_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_count <= '0;
    else if (bit_err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: scoreboard bench for ws2812_rx. Stimulus pushes the expected
// strobes into a queue before driving the line; a monitor on the falling
// clock edge pops and compares whenever the DUT raises pixel_valid,
// frame_done or a standalone bit_err.
module tb_ws2812_rx;

  typedef enum int {EV_NONE, EV_PIX, EV_FRAME, EV_ERR} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [23:0] pix;
    logic [5:0]  num;
    logic        ovf;
    logic        err;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [5:0]  px_num;
  logic        frame_done;
  logic [5:0]  frame_px;
  logic        overflow;
  logic        bit_err;
`ifdef WS2812_RX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  ws2812_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .px_num      (px_num),
    .frame_done  (frame_done),
    .frame_px    (frame_px),
    .overflow    (overflow),
    .bit_err     (bit_err)
`ifdef WS2812_RX_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard side ----------------
  task automatic push_pix(input logic [23:0] v, input logic [5:0] n);
    ev_t e;
    e.kind = EV_PIX; e.pix = v; e.num = n; e.ovf = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [5:0] n, input logic ovf, input logic err);
    ev_t e;
    e.kind = EV_FRAME; e.pix = '0; e.num = n; e.ovf = ovf; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = EV_ERR; e.pix = '0; e.num = '0; e.ovf = 1'b0; e.err = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_strobe", int'(k), int'(EV_NONE));
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(k), int'(e.kind));
    if (e.kind != k) return;
    case (k)
      EV_PIX: begin
        check("pixel", pixel, e.pix);
        check("px_num", px_num, e.num);
      end
      EV_FRAME: begin
        check("frame_px", frame_px, e.num);
        check("overflow", overflow, e.ovf);
        check("frame_bit_err", bit_err, e.err);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (pixel_valid) expect_event(EV_PIX);
      if (frame_done) expect_event(EV_FRAME);
      if (bit_err && !frame_done) expect_event(EV_ERR);
    end
  end

  // ---------------- stimulus side ----------------
  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  // Fast bits sit exactly on the decode boundaries: 10 = shortest valid
  // high (a 0), 60 = threshold (a 1).
  task automatic fast_bit(input logic b);
    drive(1'b1, b ? 60 : 10);
    drive(1'b0, 1);
  endtask

  // Nominal timing: T0H=40 / T1H=80, 125-cycle period.
  task automatic std_bit(input logic b);
    drive(1'b1, b ? 80 : 40);
    drive(1'b0, b ? 45 : 85);
  endtask

  task automatic send_px(input logic [23:0] v, input bit std);
    for (int i = 23; i >= 0; i--) begin
      if (std) std_bit(v[i]);
      else     fast_bit(v[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel"}, pixel, 24'h0);
    check({tag, "_pixel_valid"}, pixel_valid, 1'b0);
    check({tag, "_px_num"}, px_num, 6'd0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_frame_px"}, frame_px, 6'd0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_bit_err"}, bit_err, 1'b0);
`ifdef WS2812_RX_ERRCNT_EN
    check({tag, "_err_count"}, err_count, 8'd0);
`endif
  endtask

  localparam int GAP = 5020;  // a little over the 5000-cycle latch

  initial begin
    logic [23:0] gv;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Bits before the first latch gap: no strobes; the SYNC latch is silent.
    send_px(24'h123456, 1'b0);
    drive(1'b0, 6000);

    // Single pixel at nominal timing.
    push_pix(24'hA53C0F, 6'd0);
    send_px(24'hA53C0F, 1'b1);
    push_frame(6'd1, 1'b0, 1'b0);
    drive(1'b0, GAP);

    // 52-pixel frame, value = index.
    for (int i = 0; i < 52; i++) begin
      push_pix(24'(i), 6'(i));
      send_px(24'(i), 1'b0);
    end
    push_frame(6'd52, 1'b0, 1'b0);
    drive(1'b0, GAP);

    // 66 pixels: index wraps 63 -> 0, overflow held through frame_done.
    for (int i = 0; i < 66; i++) begin
      push_pix(24'h0, 6'(i % 64));
      send_px(24'h0, 1'b0);
    end
    push_frame(6'd2, 1'b1, 1'b0);
    drive(1'b0, GAP);

    // Partial pixel at latch: frame_done with bit_err, overflow cleared.
    for (int i = 0; i < 12; i++) fast_bit(i[0]);
    push_frame(6'd0, 1'b0, 1'b1);
    drive(1'b0, GAP);

    // Over-long high: bit_err, then nothing decodes until a latch gap.
    push_err();
    drive(1'b1, 200);
    drive(1'b0, 10);
    send_px(24'h00FF00, 1'b0);
    drive(1'b0, GAP);

    // Decoding resumes; reset after pixel 3.
    for (int i = 0; i < 4; i++) begin
      push_pix(24'h100 + 24'(i), 6'(i));
      send_px(24'h100 + 24'(i), 1'b0);
    end
    drive(1'b0, 10);
`ifdef WS2812_RX_ERRCNT_EN
    check("err_count_pre_reset", err_count, 8'd2);
`endif
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    drive(1'b0, GAP);

    // Post-reset pixel with a 5-cycle glitch mid-pixel; index restarts at 0.
    gv = 24'hC3A50F;
    push_pix(gv, 6'd0);
    for (int i = 23; i >= 0; i--) begin
      if (i == 11) begin
        drive(1'b0, 4);
        drive(1'b1, 5);
        drive(1'b0, 4);
      end
      fast_bit(gv[i]);
    end
    drive(1'b0, 20);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
